// File: rtl/fcpu_pkg.sv
// fcpu_pkg: shared types and constants for the fcpu core.
//  - cdb_t        : common data bus beat {rsv_id, data}
//  - CDB_W        : width of one CDB beat
//  - CDB_UNIT_*   : requester index of each functional unit on the CDB arbiter
package fcpu_pkg;

  localparam int RSV_ID_W = 4;
  localparam int DATA_W   = 32;
  localparam int CDB_W    = RSV_ID_W + DATA_W;

  typedef struct packed {
    logic [RSV_ID_W-1:0] rsv_id;
    logic [DATA_W-1:0]   data;
  } cdb_t;

  localparam int CDB_UNIT_ALU = 0;
  localparam int CDB_UNIT_MFU = 1;
  localparam int CDB_UNIT_MMU = 2;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: purely combinational round-robin grant selection.
//  Parameters: N (number of requesters, >= 2)
//  Ports:
//    req     in  N       request vector
//    ptr     in  IDX_W   highest-priority index for this decision
//    gnt     out N       one-hot grant (all zero when no request)
//    gnt_idx out IDX_W   index of the granted requester (0 when no grant)
//  The search visits ptr, ptr+1, ... wrapping modulo N; the first requester wins.
module rr_arbiter
  import fcpu_pkg::*;
#(
  parameter  int N     = 3,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  int   cand_s;
  logic found_s;

  // Priority search starting at ptr; a pointer outside 0..N-1 is folded back into range.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found_s = 1'b0;
    cand_s  = 0;
    for (int k = 0; k < N; k++) begin
      cand_s = int'(ptr) + k;
      if (cand_s >= N) begin
        cand_s = cand_s - N;
      end else begin
        cand_s = cand_s;
      end
      if (cand_s >= N) begin
        cand_s = cand_s - N;
      end else begin
        cand_s = cand_s;
      end
      for (int i = 0; i < N; i++) begin
        if (!found_s && (i == cand_s) && req[i]) begin
          gnt[i]  = 1'b1;
          gnt_idx = IDX_W'(i);
          found_s = 1'b1;
        end else begin
          found_s = found_s;
        end
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter and register stage for the common data bus.
//  Collects result beats from N_UNITS functional units (0 = alu, 1 = mfu, 2 = mmu),
//  grants at most one per cycle and broadcasts the granted beat one cycle later.
//  Parameters: N_UNITS (>= 2), CDB_W (beat width)
//  Ports:
//    clk          in  1              rising-edge clock
//    nrst         in  1              asynchronous active-low reset
//    req_cdb      in  N_UNITS*CDB_W  per-unit result beat
//    req_valid    in  N_UNITS        per-unit beat valid
//    req_ready    out N_UNITS        per-unit grant, beat consumed this cycle
//    flush        in  1              branch miss: kill grant and broadcast
//    cdb          out CDB_W          broadcast beat
//    cdb_valid    out 1              broadcast valid
//    perf_grants  out N_UNITS*32     per-unit saturating grant counters
//                                    (only when CDB_ARB_PERF_EN is defined)
//  Optional feature macro: CDB_ARB_PERF_EN
module cdb_arbiter
  import fcpu_pkg::*;
#(
  parameter  int N_UNITS = 3,
  parameter  int CDB_W   = fcpu_pkg::CDB_W,
  localparam int PTR_W   = $clog2(N_UNITS)
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic [N_UNITS*CDB_W-1:0]   req_cdb,
  input  logic [N_UNITS-1:0]         req_valid,
  output logic [N_UNITS-1:0]         req_ready,
  input  logic                       flush,
  output logic [CDB_W-1:0]           cdb,
  output logic                       cdb_valid
`ifdef CDB_ARB_PERF_EN
  ,
  output logic [N_UNITS*32-1:0]      perf_grants
`endif
);

  logic [PTR_W-1:0]   rr_ptr_r;
  logic [N_UNITS-1:0] gnt_s;
  logic [PTR_W-1:0]   gnt_idx_s;
  logic               grant_any_s;
  logic [CDB_W-1:0]   beat_s;
  logic [CDB_W-1:0]   cdb_r;
  logic               cdb_valid_r;

  rr_arbiter #(.N(N_UNITS)) u_rr_arbiter (
    .req     (req_valid),
    .ptr     (rr_ptr_r),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s)
  );

  // Grant qualification: nothing is consumed while flushing or held in reset.
  always_comb begin
    if (flush || !nrst) begin
      req_ready = '0;
    end else begin
      req_ready = gnt_s;
    end
  end

  // One-hot AND-OR mux of the granted beat.
  always_comb begin
    beat_s = '0;
    for (int i = 0; i < N_UNITS; i++) begin
      if (req_ready[i]) begin
        beat_s = beat_s | req_cdb[i*CDB_W +: CDB_W];
      end else begin
        beat_s = beat_s;
      end
    end
  end

  assign grant_any_s = |req_ready;

  // Broadcast register and round-robin pointer; an idle or flushed cycle drives a zero bus.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cdb_r       <= '0;
      cdb_valid_r <= 1'b0;
      rr_ptr_r    <= '0;
    end else if (grant_any_s) begin
      cdb_r       <= beat_s;
      cdb_valid_r <= 1'b1;
      if (gnt_idx_s == PTR_W'(N_UNITS - 1)) begin
        rr_ptr_r <= '0;
      end else begin
        rr_ptr_r <= gnt_idx_s + PTR_W'(1);
      end
    end else begin
      cdb_r       <= '0;
      cdb_valid_r <= 1'b0;
      rr_ptr_r    <= rr_ptr_r;
    end
  end

  // A flush in the cycle after a grant must also squash the beat already on the bus,
  // so the registered broadcast is masked by flush before it leaves the block.
  always_comb begin
    if (flush) begin
      cdb       = '0;
      cdb_valid = 1'b0;
    end else begin
      cdb       = cdb_r;
      cdb_valid = cdb_valid_r;
    end
  end

`ifdef CDB_ARB_PERF_EN
  logic [31:0] perf_cnt_r [N_UNITS];

  // Saturating per-unit transfer counters; cleared only by reset.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < N_UNITS; i++) begin
        perf_cnt_r[i] <= 32'd0;
      end
    end else begin
      for (int i = 0; i < N_UNITS; i++) begin
        if (req_valid[i] && req_ready[i] && (perf_cnt_r[i] != 32'hFFFF_FFFF)) begin
          perf_cnt_r[i] <= perf_cnt_r[i] + 32'd1;
        end else begin
          perf_cnt_r[i] <= perf_cnt_r[i];
        end
      end
    end
  end

  // Flatten the counters onto the perf port, unit i at bits [i*32 +: 32].
  always_comb begin
    perf_grants = '0;
    for (int i = 0; i < N_UNITS; i++) begin
      perf_grants[i*32 +: 32] = perf_cnt_r[i];
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: table-driven check of cdb_arbiter grants plus a scoreboard of
// expected broadcast beats, and hand-written reset sequences.
module tb_cdb_arbiter;
  import fcpu_pkg::*;

  localparam int N = 3;
  localparam int W = fcpu_pkg::CDB_W;

  logic           clk = 1'b0;
  logic           nrst;
  logic [N*W-1:0] req_cdb;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic           flush;
  logic [W-1:0]   cdb;
  logic           cdb_valid;
`ifdef CDB_ARB_PERF_EN
  logic [N*32-1:0] perf_grants;
`endif

  always #5 clk = ~clk;

  cdb_arbiter #(.N_UNITS(N), .CDB_W(W)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .req_cdb   (req_cdb),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .flush     (flush),
    .cdb       (cdb),
    .cdb_valid (cdb_valid)
`ifdef CDB_ARB_PERF_EN
    ,
    .perf_grants (perf_grants)
`endif
  );

  typedef struct {
    logic [N-1:0] valid;
    logic         fl;
    logic [N-1:0] exp_ready;
  } vec_t;

  typedef struct {
    logic         v;
    logic [W-1:0] d;
  } sb_t;

  vec_t vecs [21];
  sb_t  sb_q [$];
  int   seq   [N];
  int   cnt   [N];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [W-1:0] mk_beat(input int u, input int s);
    cdb_t b;
    b.rsv_id = RSV_ID_W'(u * 5 + s + 1);
    b.data   = 32'hC0DE_0000 | 32'(u << 12) | 32'(s);
    return b;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_beats();
    for (int u = 0; u < N; u++) begin
      req_cdb[u*W +: W] = mk_beat(u, seq[u]);
    end
  endtask

  task automatic model_reset();
    sb_q.delete();
    sb_q.push_back('{v: 1'b0, d: '0});
    for (int u = 0; u < N; u++) cnt[u] = 0;
  endtask

  // One cycle: drive, sample at the negedge, update the scoreboard, advance past the posedge.
  task automatic step(input string name, input logic [N-1:0] v, input logic f,
                      input logic [N-1:0] exp_ready);
    sb_t e;
    req_valid = v;
    flush     = f;
    drive_beats();
    #4;
    check({name, " ready"}, 64'(req_ready), 64'(exp_ready));
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard: got empty queue expected an entry", name);
    end else begin
      e = sb_q.pop_front();
      if (f) begin
        e.v = 1'b0;
        e.d = '0;
      end
      check({name, " cdb_valid"}, 64'(cdb_valid), 64'(e.v));
      check({name, " cdb"}, 64'(cdb), 64'(e.d));
    end
    e.v = 1'b0;
    e.d = '0;
    for (int u = 0; u < N; u++) begin
      if (exp_ready[u]) begin
        e.v = 1'b1;
        e.d = mk_beat(u, seq[u]);
        seq[u]++;
        cnt[u]++;
      end
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // valid, flush, expected req_ready
    vecs[0]  = '{3'b111, 1'b0, 3'b001};
    vecs[1]  = '{3'b111, 1'b0, 3'b010};
    vecs[2]  = '{3'b111, 1'b0, 3'b100};
    vecs[3]  = '{3'b111, 1'b0, 3'b001};
    vecs[4]  = '{3'b111, 1'b0, 3'b010};
    vecs[5]  = '{3'b111, 1'b0, 3'b100};
    vecs[6]  = '{3'b100, 1'b0, 3'b100};
    vecs[7]  = '{3'b100, 1'b0, 3'b100};
    vecs[8]  = '{3'b100, 1'b0, 3'b100};
    vecs[9]  = '{3'b100, 1'b0, 3'b100};
    vecs[10] = '{3'b010, 1'b0, 3'b010};
    vecs[11] = '{3'b011, 1'b0, 3'b001};
    vecs[12] = '{3'b000, 1'b0, 3'b000};
    vecs[13] = '{3'b000, 1'b0, 3'b000};
    vecs[14] = '{3'b001, 1'b1, 3'b000};
    vecs[15] = '{3'b001, 1'b0, 3'b001};
    vecs[16] = '{3'b001, 1'b1, 3'b000};
    vecs[17] = '{3'b001, 1'b0, 3'b001};
    vecs[18] = '{3'b110, 1'b0, 3'b010};
    vecs[19] = '{3'b110, 1'b0, 3'b100};
    vecs[20] = '{3'b000, 1'b0, 3'b000};

    for (int u = 0; u < N; u++) begin
      seq[u] = 0;
      cnt[u] = 0;
    end

    // Reset with every unit requesting: nothing granted, bus zero.
    nrst      = 1'b0;
    flush     = 1'b0;
    req_valid = 3'b111;
    drive_beats();
    #8;
    check("reset ready", 64'(req_ready), 64'd0);
    check("reset cdb_valid", 64'(cdb_valid), 64'd0);
    check("reset cdb", 64'(cdb), 64'd0);
`ifdef CDB_ARB_PERF_EN
    check("reset perf", 64'(perf_grants), 64'd0);
`endif
    @(posedge clk);
    #1;
    nrst = 1'b1;
    model_reset();

    for (int i = 0; i < 21; i++) begin
      step($sformatf("vec%0d", i), vecs[i].valid, vecs[i].fl, vecs[i].exp_ready);
`ifdef CDB_ARB_PERF_EN
      if (i == 5) begin
        for (int u = 0; u < N; u++) begin
          check($sformatf("perf rr unit%0d", u), 64'(perf_grants[u*32 +: 32]), 64'd2);
        end
      end
`endif
    end

    // Reset asserted while a beat is on the bus: bus clears at once, pointer returns to 0.
    step("pre_rst", 3'b111, 1'b0, 3'b001);
    nrst = 1'b0;
    #1;
    check("midrst cdb_valid", 64'(cdb_valid), 64'd0);
    check("midrst cdb", 64'(cdb), 64'd0);
    check("midrst ready", 64'(req_ready), 64'd0);
    #1;
    nrst = 1'b1;
    model_reset();
    step("post_rst", 3'b111, 1'b0, 3'b001);
    step("post_idle", 3'b000, 1'b0, 3'b000);

`ifdef CDB_ARB_PERF_EN
    for (int u = 0; u < N; u++) begin
      check($sformatf("perf final unit%0d", u), 64'(perf_grants[u*32 +: 32]), 64'(cnt[u]));
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
